bus_arbiter: RTL and testbench

Single-clock arbiter for the shared memory port M2, split between the CPU data path and the DMA controller. Takes the DMA bus request (BR) and the CPU's per-access request, and issues the bus grant (BG) and the CPU stall. CPU accesses win by default. Each side is protected from starvation by a saturating wait counter, so a long DMA burst is paused at a safe point and later resumed.

---
 rtl/bus_arbiter.sv | 102 ++++++++++
 tb/tb_bus_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Arbiter for shared memory port M2 between the CPU data path and the DMA controller.
// CPU wins by default; saturating wait counters keep either side from starving.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | nobody owns M2
// S_CPU   | CPU owns M2
// S_DMA   | DMA owns M2, BG high
// S_PAUSE | DMA grant paused to serve a starved CPU, DMA still pending
module bus_arbiter #(
   parameter int DMA_WAIT_MAX = 8,
   parameter int CPU_WAIT_MAX = 4
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       BR,
   input  logic       cpu_req,
   input  logic       M2busy,
   output logic       BG,
   output logic       cpu_stall,
   output logic [1:0] owner,
   output logic [7:0] grant_count
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CPU   = 2'd1;
   localparam logic [1:0] S_DMA   = 2'd2;
   localparam logic [1:0] S_PAUSE = 2'd3;

   // Thresholds above the counter range clamp to saturation so urgency stays reachable.
   localparam logic [3:0] DMA_LIM = (DMA_WAIT_MAX > 15) ? 4'd15 : 4'(DMA_WAIT_MAX);
   localparam logic [3:0] CPU_LIM = (CPU_WAIT_MAX > 15) ? 4'd15 : 4'(CPU_WAIT_MAX);

   logic [1:0] r_state;
   logic [1:0] w_next;
   logic       r_bg;
   logic [3:0] r_dma_wait;
   logic [3:0] r_cpu_wait;
   logic [7:0] r_grant_count;
   logic       w_dma_urgent;
   logic       w_cpu_urgent;
   logic       w_grant_rise;
   logic       w_stall;

   assign w_dma_urgent = (r_dma_wait >= DMA_LIM);
   assign w_cpu_urgent = (r_cpu_wait >= CPU_LIM);
   assign w_stall      = cpu_req &
                         ~((r_state == S_CPU) | (r_state == S_PAUSE) |
                           ((r_state == S_IDLE) & ~w_dma_urgent));
   assign w_grant_rise = (w_next == S_DMA) & (r_state != S_DMA);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (cpu_req && !w_dma_urgent) w_next = S_CPU;
            else if (BR)                  w_next = S_DMA;
         end
         S_CPU: begin
            if (!M2busy) begin
               if (BR && w_dma_urgent) w_next = S_DMA;
               else if (!cpu_req)      w_next = BR ? S_DMA : S_IDLE;
            end
         end
         S_DMA: begin
            if (!BR)                               w_next = S_IDLE;
            else if (w_cpu_urgent && !M2busy)      w_next = S_PAUSE;
         end
         default: begin
            // BR dropping here is only acted on once the CPU lets go
            if (!cpu_req && !M2busy) w_next = BR ? S_DMA : S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state       <= S_IDLE;
         r_bg          <= 1'b0;
         r_dma_wait    <= 4'd0;
         r_cpu_wait    <= 4'd0;
         r_grant_count <= 8'd0;
      end else begin
         r_state <= w_next;
         r_bg    <= (w_next == S_DMA);

         if (!BR || w_grant_rise)               r_dma_wait <= 4'd0;
         else if (!r_bg && r_dma_wait != 4'hF) r_dma_wait <= r_dma_wait + 4'd1;

         if (!w_stall)                r_cpu_wait <= 4'd0;
         else if (r_cpu_wait != 4'hF) r_cpu_wait <= r_cpu_wait + 4'd1;

         if (w_grant_rise) r_grant_count <= r_grant_count + 8'd1;
      end
   end

   assign BG          = r_bg;
   assign owner       = r_state;
   assign grant_count = r_grant_count;
   assign cpu_stall   = w_stall;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: each step drives inputs, queues the expected
// post-edge outputs, checks cpu_stall mid-cycle, then pops and checks after the edge.
module tb_bus_arbiter;

   logic       Clk;
   logic       Reset;
   logic       BR;
   logic       cpu_req;
   logic       M2busy;
   logic       BG;
   logic       cpu_stall;
   logic [1:0] owner;
   logic [7:0] grant_count;

   typedef struct {
      logic [1:0] owner;
      logic       bg;
      logic [7:0] gc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   logic [7:0] g;

   bus_arbiter #(.DMA_WAIT_MAX(8), .CPU_WAIT_MAX(4)) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .BR          (BR),
      .cpu_req     (cpu_req),
      .M2busy      (M2busy),
      .BG          (BG),
      .cpu_stall   (cpu_stall),
      .owner       (owner),
      .grant_count (grant_count)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // exp_stall < 0 means cpu_stall is not checked in this cycle
   task automatic step(input logic rst, input logic br, input logic req, input logic busy,
                       input int exp_stall, input logic [1:0] exp_owner, input logic [7:0] exp_gc);
      exp_t e;
      exp_t got;
      logic want_stall;
      Reset   = rst;
      BR      = br;
      cpu_req = req;
      M2busy  = busy;
      e.owner = exp_owner;
      e.bg    = (exp_owner == 2'd2);
      e.gc    = exp_gc;
      sb.push_back(e);
      #1;
      if (exp_stall >= 0) begin
         want_stall = (exp_stall != 0);
         total++;
         assert (cpu_stall === want_stall) else begin
            bad++;
            $error("FAIL stall t=%0t got=%b exp=%b", $time, cpu_stall, want_stall);
         end
      end
      @(posedge Clk);
      #1;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $error("FAIL scoreboard_empty t=%0t got=0 exp=1", $time);
      end else begin
         got = sb.pop_front();
         total++;
         assert (owner === got.owner) else begin
            bad++;
            $error("FAIL owner t=%0t got=%0d exp=%0d", $time, owner, got.owner);
         end
         total++;
         assert (BG === got.bg) else begin
            bad++;
            $error("FAIL bg t=%0t got=%b exp=%b", $time, BG, got.bg);
         end
         total++;
         assert (grant_count === got.gc) else begin
            bad++;
            $error("FAIL grant_count t=%0t got=%0d exp=%0d", $time, grant_count, got.gc);
         end
      end
   endtask

   initial begin
      Reset = 1'b1; BR = 1'b1; cpu_req = 1'b1; M2busy = 1'b0;

      // reset with both requests active, then CPU wins first edge
      step(1, 1, 1, 0, -1, 2'd0, 8'd0);
      step(1, 1, 1, 0,  0, 2'd0, 8'd0);
      step(0, 1, 1, 0,  0, 2'd1, 8'd0);
      step(0, 0, 0, 0,  0, 2'd0, 8'd0);

      // plain DMA grant and release
      step(0, 1, 0, 0, 0, 2'd2, 8'd1);
      step(0, 1, 0, 0, 0, 2'd2, 8'd1);
      step(0, 0, 0, 0, 0, 2'd0, 8'd1);

      // release with a CPU request waiting
      step(0, 1, 0, 0, 0, 2'd2, 8'd2);
      step(0, 0, 1, 0, 1, 2'd0, 8'd2);
      step(0, 0, 1, 0, 0, 2'd1, 8'd2);
      step(0, 0, 0, 0, 0, 2'd0, 8'd2);

      // CPU hogs the bus while BR waits; DMA wins after 8 waiting cycles
      step(0, 1, 1, 0, 0, 2'd1, 8'd2);
      for (int i = 0; i < 7; i++) step(0, 1, 1, 0, 0, 2'd1, 8'd2);
      step(0, 1, 1, 1, 0, 2'd1, 8'd2);
      step(0, 1, 1, 0, 0, 2'd2, 8'd3);

      // stalled CPU pauses the DMA, held off by M2busy for 3 cycles
      for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 1, 2'd2, 8'd3);
      for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 1, 2'd2, 8'd3);
      step(0, 1, 1, 0, 1, 2'd3, 8'd3);
      step(0, 1, 1, 0, 0, 2'd3, 8'd3);
      step(0, 1, 0, 0, 0, 2'd2, 8'd4);
      step(0, 0, 0, 0, 0, 2'd0, 8'd4);

      // BR drops during PAUSE: exit still waits for CPU and M2busy
      step(0, 1, 0, 0, 0, 2'd2, 8'd5);
      for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 1, 2'd2, 8'd5);
      step(0, 1, 1, 0, 1, 2'd3, 8'd5);
      step(0, 0, 1, 0, 0, 2'd3, 8'd5);
      step(0, 0, 0, 1, 0, 2'd3, 8'd5);
      step(0, 0, 0, 0, 0, 2'd0, 8'd5);

      // grant counter wraps 255 -> 0
      g = 8'd5;
      for (int i = 0; i < 251; i++) begin
         g = g + 8'd1;
         step(0, 1, 0, 0, 0, 2'd2, g);
         step(0, 0, 0, 0, 0, 2'd0, g);
      end
      g = g + 8'd1;
      step(0, 1, 0, 0, 0, 2'd2, g);

      // reset in the middle of a busy DMA grant
      step(0, 1, 0, 1, 0, 2'd2, 8'd1);
      step(1, 1, 0, 1, 0, 2'd0, 8'd0);
      step(0, 1, 0, 1, 0, 2'd2, 8'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
